// File: rtl/mux4x1_if.sv
// mux4x1_if: bundles the four data sources, the select and the steered
// output of the registered 4:1 multiplexer.
//   A, B, C, D : WIDTH-bit data sources (chosen by S = 00, 01, 10, 11)
//   S          : 2-bit select
//   Y          : WIDTH-bit selected word, driven by the mux
// master drives sources/select and observes Y; slave is the mux side.
interface mux4x1_if #(
  parameter int WIDTH = 2
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] C;
  logic [WIDTH-1:0] D;
  logic [1:0]       S;
  logic [WIDTH-1:0] Y;

  modport master (output A, B, C, D, S, input Y);
  modport slave  (input A, B, C, D, S, output Y);
endinterface

// File: rtl/mux4x1.sv
// mux4x1: registered 4-to-1 multiplexer.
// Selects one of four WIDTH-bit words by S and passes it through a chain of
// STAGES registers (0..4). STAGES=0 gives a purely combinational path.
// Ports:
//   clk   : rising-edge clock for the output register chain
//   rst_n : asynchronous active-low reset, clears every register in the chain
//   bus   : mux4x1_if slave (A, B, C, D, S in; Y out)
module mux4x1 #(
  parameter int WIDTH  = 2,
  parameter int STAGES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  mux4x1_if.slave    bus
);

  logic [WIDTH-1:0] sel;

  // Every 2-bit code names a source, so the case is complete as written.
  always_comb begin
    sel = bus.A;
    case (bus.S)
      2'b00: sel = bus.A;
      2'b01: sel = bus.B;
      2'b10: sel = bus.C;
      2'b11: sel = bus.D;
    endcase
  end

  generate
    if (STAGES == 0) begin : g_comb
      // Clock and reset have no function without registers.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign bus.Y = sel;
    end else begin : g_pipe
      // pipe[0] captures the selection; pipe[STAGES-1] drives Y.
      logic [STAGES-1:0][WIDTH-1:0] pipe;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pipe <= '0;
        end else begin
          pipe[0] <= sel;
          for (int i = 1; i < STAGES; i++) pipe[i] <= pipe[i-1];
        end
      end

      assign bus.Y = pipe[STAGES-1];
    end
  endgenerate

endmodule

// File: tb/tb_mux4x1.sv
module tb_mux4x1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mux4x1_if #(.WIDTH(2)) b1 ();
  mux4x1_if #(.WIDTH(2)) b3 ();
  mux4x1_if #(.WIDTH(2)) b0 ();
  mux4x1_if #(.WIDTH(8)) b8 ();

  mux4x1 #(.WIDTH(2), .STAGES(1)) u_s1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  mux4x1 #(.WIDTH(2), .STAGES(3)) u_s3 (.clk(clk), .rst_n(rst_n), .bus(b3));
  mux4x1 #(.WIDTH(2), .STAGES(0)) u_s0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  mux4x1 #(.WIDTH(8), .STAGES(1)) u_w8 (.clk(clk), .rst_n(rst_n), .bus(b8));

  int n_vec = 0;
  int n_err = 0;

  // Reference: newest captured selection at index 0; Y of an N-stage mux is
  // the selection captured N edges ago, or 0 if fewer captures since reset.
  logic [7:0] hist2[$];
  logic [7:0] hist8[$];

  typedef struct packed {
    logic [1:0] a, b, c, d, s;
    logic [1:0] y;
    logic [7:0] y8;
  } vec_t;
  vec_t tbl[9];

  function automatic logic [7:0] pick(input logic [7:0] a, b, c, d,
                                      input logic [1:0] s);
    logic [7:0] src[4];
    src[0] = a; src[1] = b; src[2] = c; src[3] = d;
    return src[s];
  endfunction

  function automatic logic [7:0] expd(input int k, input bit wide);
    if (wide) return (hist8.size() >= k) ? hist8[k-1] : 8'h00;
    return (hist2.size() >= k) ? hist2[k-1] : 8'h00;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive2(input logic [1:0] a, b, c, d, s);
    b1.A = a; b1.B = b; b1.C = c; b1.D = d; b1.S = s;
    b3.A = a; b3.B = b; b3.C = c; b3.D = d; b3.S = s;
    b0.A = a; b0.B = b; b0.C = c; b0.D = d; b0.S = s;
  endtask

  task automatic drive8(input logic [7:0] a, b, c, d, input logic [1:0] s);
    b8.A = a; b8.B = b; b8.C = c; b8.D = d; b8.S = s;
  endtask

  // Inputs are stable here (driven 1 time unit after the previous edge).
  task automatic tick();
    if (rst_n) begin
      hist2.push_front(pick(8'(b1.A), 8'(b1.B), 8'(b1.C), 8'(b1.D), b1.S));
      hist8.push_front(pick(b8.A, b8.B, b8.C, b8.D, b8.S));
      if (hist2.size() > 8) void'(hist2.pop_back());
      if (hist8.size() > 8) void'(hist8.pop_back());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".s1"}, 8'(b1.Y), expd(1, 1'b0));
    chk({tag, ".s3"}, 8'(b3.Y), expd(3, 1'b0));
    chk({tag, ".w8"}, b8.Y, expd(1, 1'b1));
    chk({tag, ".s0"}, 8'(b0.Y), pick(8'(b0.A), 8'(b0.B), 8'(b0.C), 8'(b0.D), b0.S));
  endtask

  initial begin
    //            a      b      c      d      s      y      y8
    tbl[0] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 8'hA5};
    tbl[1] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd1, 8'h3C};
    tbl[2] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd2, 8'hFF};
    tbl[3] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 8'h00};
    tbl[4] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd2, 8'hFF};
    tbl[5] = '{2'd0, 2'd1, 2'd1, 2'd3, 2'd2, 2'd1, 8'hFF}; // C 10 -> 01
    tbl[6] = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 8'hFF}; // A/B/D only
    tbl[7] = '{2'd2, 2'd0, 2'd3, 2'd1, 2'd0, 2'd2, 8'hA5}; // S and data together
    tbl[8] = '{2'd2, 2'd0, 2'd3, 2'd1, 2'd3, 2'd1, 8'h00};

    // Reset held with clock running.
    drive2(2'd0, 2'd1, 2'd2, 2'd3, 2'd3);
    drive8(8'hA5, 8'h3C, 8'hFF, 8'h00, 2'd3);
    #1;
    chk("rst.s1", 8'(b1.Y), 8'h00);
    chk("rst.s3", 8'(b3.Y), 8'h00);
    chk("rst.w8", b8.Y, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_hold.s1", 8'(b1.Y), 8'h00);
      chk_all("rst_hold");
    end
    rst_n = 1'b1;
    tick();
    chk("rel.s1", 8'(b1.Y), 8'h03);
    chk("rel.s3_wait", 8'(b3.Y), 8'h00);
    chk_all("rel");
    tick();
    tick();
    chk("rel.s3", 8'(b3.Y), 8'h03);

    // Table-driven sweep and data changes.
    for (int i = 0; i < 9; i++) begin
      drive2(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d, tbl[i].s);
      drive8(8'hA5, 8'h3C, 8'hFF, 8'h00, tbl[i].s);
      #1;
      chk("tbl.comb", 8'(b0.Y), 8'(tbl[i].y));
      tick();
      chk("tbl.s1", 8'(b1.Y), 8'(tbl[i].y));
      chk("tbl.w8", b8.Y, tbl[i].y8);
      chk_all("tbl");
    end

    // Three-stage latency: S 00 -> 11.
    drive2(2'd0, 2'd1, 2'd2, 2'd3, 2'd0);
    for (int i = 0; i < 3; i++) tick();
    chk("lat.pre", 8'(b3.Y), 8'h00);
    drive2(2'd0, 2'd1, 2'd2, 2'd3, 2'd3);
    tick(); chk("lat.e1", 8'(b3.Y), 8'h00);
    tick(); chk("lat.e2", 8'(b3.Y), 8'h00);
    tick(); chk("lat.e3", 8'(b3.Y), 8'h03);
    chk_all("lat");

    // Asynchronous reset between edges.
    drive8(8'hA5, 8'h3C, 8'hFF, 8'h00, 2'd2);
    tick();
    chk("mid.pre", 8'(b1.Y), 8'h03);
    #2;
    rst_n = 1'b0;
    hist2.delete();
    hist8.delete();
    #1;
    chk("mid.s1", 8'(b1.Y), 8'h00);
    chk("mid.s3", 8'(b3.Y), 8'h00);
    chk("mid.w8", b8.Y, 8'h00);
    tick();
    chk_all("mid_hold");
    rst_n = 1'b1;
    tick();
    chk("mid.rel", 8'(b1.Y), 8'h03);
    chk_all("mid_rel");

    // Randomized traffic against the reference.
    for (int i = 0; i < 300; i++) begin
      drive2(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom));
      drive8(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 2'($urandom));
      #1;
      chk("rnd.comb", 8'(b0.Y), pick(8'(b0.A), 8'(b0.B), 8'(b0.C), 8'(b0.D), b0.S));
      tick();
      chk_all("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
